// File: rtl/me_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : me_result_collector
// Purpose  : Captures one motion-estimation result per search run, tags it with
//            a block index and quality class, and queues it for a consumer.
// Revision : 1.0 - initial release
// ============================================================================
module me_result_collector #(
   parameter int         FIFO_DEPTH = 4,
   parameter int         BLK_IDX_W  = 8,
   parameter logic [7:0] SAD_THRESH = 8'd32
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start_signal,
   input  logic                              process_completed,
   input  logic [7:0]                        best_distance,
   input  logic [3:0]                        motion_vector_x,
   input  logic [3:0]                        motion_vector_y,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [BLK_IDX_W-1:0]              out_blk_idx,
   output logic [7:0]                        out_sad,
   output logic [7:0]                        out_mv_x,
   output logic [7:0]                        out_mv_y,
   output logic [1:0]                        out_class,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic                              overflow_sticky
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]           r_state;
   logic [1:0]           w_next_state;
   logic                 r_done_q;
   logic                 w_rise;
   logic                 w_capture;
   logic [BLK_IDX_W-1:0] r_blk_idx;
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;
   logic                 r_overflow;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic                 w_push;

   logic [BLK_IDX_W-1:0] r_idx_mem [FIFO_DEPTH];
   logic [7:0]           r_sad_mem [FIFO_DEPTH];
   logic [3:0]           r_mvx_mem [FIFO_DEPTH];
   logic [3:0]           r_mvy_mem [FIFO_DEPTH];

   assign w_rise = process_completed & ~r_done_q;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_done_q <= 1'b0;
      end else begin
         r_state  <= w_next_state;
         r_done_q <= process_completed;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (start_signal) w_next_state = S_ARMED;
         S_ARMED: begin
            if (!start_signal)  w_next_state = S_IDLE;
            else if (w_rise)    w_next_state = S_DONE;
         end
         S_DONE:  if (!start_signal) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_capture = (r_state == S_ARMED) && start_signal && w_rise;
   end

   // ---------------------------------------------------------------- FIFO
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_pop   = ~w_empty & out_ready;
   // A full FIFO still accepts a capture when the head leaves on the same edge.
   assign w_push  = w_capture & (~w_full | w_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_blk_idx  <= '0;
         r_overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_idx_mem[i] <= '0;
            r_sad_mem[i] <= '0;
            r_mvx_mem[i] <= '0;
            r_mvy_mem[i] <= '0;
         end
      end else begin
         if (w_capture) begin
            r_blk_idx <= r_blk_idx + 1'b1;
         end
         if (w_capture && !w_push) begin
            r_overflow <= 1'b1;
         end
         if (w_push) begin
            r_idx_mem[r_wr_ptr] <= r_blk_idx;
            r_sad_mem[r_wr_ptr] <= best_distance;
            r_mvx_mem[r_wr_ptr] <= motion_vector_x;
            r_mvy_mem[r_wr_ptr] <= motion_vector_y;
            r_wr_ptr            <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   assign out_valid       = ~w_empty;
   assign out_blk_idx     = r_idx_mem[r_rd_ptr];
   assign out_sad         = r_sad_mem[r_rd_ptr];
   assign out_mv_x        = {{4{r_mvx_mem[r_rd_ptr][3]}}, r_mvx_mem[r_rd_ptr]};
   assign out_mv_y        = {{4{r_mvy_mem[r_rd_ptr][3]}}, r_mvy_mem[r_rd_ptr]};
   assign fifo_count      = r_count;
   assign overflow_sticky = r_overflow;

   always_comb begin
      out_class = 2'b10;
      if (out_sad == 8'h00)            out_class = 2'b00;
      else if (out_sad == 8'hFF)       out_class = 2'b11;
      else if (out_sad <= SAD_THRESH)  out_class = 2'b01;
   end

endmodule
`default_nettype wire

// File: tb/tb_me_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_result_collector
// Purpose  : Directed scoreboard bench for me_result_collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_result_collector;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_signal;
   logic       process_completed;
   logic [7:0] best_distance;
   logic [3:0] motion_vector_x;
   logic [3:0] motion_vector_y;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_blk_idx;
   logic [7:0] out_sad;
   logic [7:0] out_mv_x;
   logic [7:0] out_mv_y;
   logic [1:0] out_class;
   logic [2:0] fifo_count;
   logic       overflow_sticky;

   typedef struct {
      logic [7:0] idx;
      logic [7:0] sad;
      logic [7:0] mx;
      logic [7:0] my;
      logic [1:0] cls;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_idx;
   int         n_checks = 0;
   int         n_fail   = 0;

   me_result_collector #(
      .FIFO_DEPTH (4),
      .BLK_IDX_W  (8),
      .SAD_THRESH (8'd32)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .start_signal      (start_signal),
      .process_completed (process_completed),
      .best_distance     (best_distance),
      .motion_vector_x   (motion_vector_x),
      .motion_vector_y   (motion_vector_y),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_blk_idx       (out_blk_idx),
      .out_sad           (out_sad),
      .out_mv_x          (out_mv_x),
      .out_mv_y          (out_mv_y),
      .out_class         (out_class),
      .fifo_count        (fifo_count),
      .overflow_sticky   (overflow_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every accepted head entry is compared against the scoreboard.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_entry", 32'(out_blk_idx), 32'hFFFF_FFFF);
         end else begin
            check("blk_idx", 32'(out_blk_idx), 32'(sb[0].idx));
            check("sad",     32'(out_sad),     32'(sb[0].sad));
            check("mv_x",    32'(out_mv_x),    32'(sb[0].mx));
            check("mv_y",    32'(out_mv_y),    32'(sb[0].my));
            check("class",   32'(out_class),   32'(sb[0].cls));
            void'(sb.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst_n             = 1'b0;
      start_signal      = 1'b0;
      process_completed = 1'b0;
      sb.delete();
      exp_idx = 8'd0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run(input logic [7:0] sad, input logic [3:0] mx, input logic [3:0] my,
                      input logic [7:0] emx, input logic [7:0] emy, input logic [1:0] ecls,
                      input bit push, input int hold, input bit pop_at_cap);
      @(posedge clk); #1 start_signal = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      best_distance     = sad;
      motion_vector_x   = mx;
      motion_vector_y   = my;
      process_completed = 1'b1;
      if (pop_at_cap) out_ready = 1'b1;
      if (push) sb.push_back('{exp_idx, sad, emx, emy, ecls});
      exp_idx = exp_idx + 8'd1;
      @(posedge clk); #1;
      if (pop_at_cap) out_ready = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
      process_completed = 1'b0;
      start_signal      = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int cyc = 0;
      out_ready = 1'b1;
      while (sb.size() != 0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("drain_scoreboard_empty", 32'(sb.size()), 32'd0);
      @(posedge clk); #1;
      check("drain_fifo_count", 32'(fifo_count), 32'd0);
      check("drain_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      out_ready       = 1'b0;
      best_distance   = 8'd0;
      motion_vector_x = 4'd0;
      motion_vector_y = 4'd0;
      do_reset();

      check("rst_out_valid", 32'(out_valid),       32'd0);
      check("rst_blk_idx",   32'(out_blk_idx),     32'd0);
      check("rst_sad",       32'(out_sad),         32'd0);
      check("rst_mv_x",      32'(out_mv_x),        32'd0);
      check("rst_mv_y",      32'(out_mv_y),        32'd0);
      check("rst_class",     32'(out_class),       32'd0);
      check("rst_count",     32'(fifo_count),      32'd0);
      check("rst_overflow",  32'(overflow_sticky), 32'd0);

      // T1: single run
      out_ready = 1'b1;
      run(8'd0, 4'hD, 4'h3, 8'hFD, 8'h03, 2'b00, 1'b1, 0, 1'b0);
      drain();

      // T2: done held high for many cycles yields one entry
      out_ready = 1'b0;
      run(8'd20, 4'h1, 4'h2, 8'h01, 8'h02, 2'b01, 1'b1, 10, 1'b0);
      check("t2_count_one", 32'(fifo_count), 32'd1);
      drain();

      // T4: class boundaries and sign extension
      out_ready = 1'b1;
      run(8'd32, 4'h7, 4'h0, 8'h07, 8'h00, 2'b01, 1'b1, 0, 1'b0);
      run(8'd33, 4'h8, 4'hF, 8'hF8, 8'hFF, 2'b10, 1'b1, 0, 1'b0);
      run(8'hFF, 4'h2, 4'hE, 8'h02, 8'hFE, 2'b11, 1'b1, 0, 1'b0);
      run(8'd0,  4'h0, 4'h8, 8'h00, 8'hF8, 2'b00, 1'b1, 0, 1'b0);
      run(8'd1,  4'h4, 4'h5, 8'h04, 8'h05, 2'b01, 1'b1, 0, 1'b0);
      drain();

      // T3: backpressure and overflow
      do_reset();
      out_ready = 1'b0;
      run(8'd10, 4'h1, 4'h1, 8'h01, 8'h01, 2'b01, 1'b1, 0, 1'b0);
      run(8'd40, 4'h2, 4'h2, 8'h02, 8'h02, 2'b10, 1'b1, 0, 1'b0);
      run(8'd50, 4'h3, 4'h3, 8'h03, 8'h03, 2'b10, 1'b1, 0, 1'b0);
      run(8'd60, 4'hC, 4'h4, 8'hFC, 8'h04, 2'b10, 1'b1, 0, 1'b0);
      run(8'd70, 4'h5, 4'h5, 8'h05, 8'h05, 2'b10, 1'b0, 0, 1'b0);
      check("t3_count_full", 32'(fifo_count),      32'd4);
      check("t3_overflow",   32'(overflow_sticky), 32'd1);
      drain();
      run(8'd5, 4'h6, 4'h9, 8'h06, 8'hF9, 2'b01, 1'b1, 0, 1'b0);
      drain();
      check("t3_overflow_sticky", 32'(overflow_sticky), 32'd1);

      // T5: abort leaves index unchanged; full with simultaneous pop/push
      do_reset();
      @(posedge clk); #1 start_signal = 1'b1;
      repeat (3) @(posedge clk);
      #1 start_signal = 1'b0;
      @(posedge clk); #1;
      check("t5_abort_count", 32'(fifo_count), 32'd0);
      out_ready = 1'b0;
      run(8'd3,  4'h1, 4'h0, 8'h01, 8'h00, 2'b01, 1'b1, 0, 1'b0);
      run(8'd4,  4'h2, 4'h0, 8'h02, 8'h00, 2'b01, 1'b1, 0, 1'b0);
      run(8'd5,  4'h3, 4'h0, 8'h03, 8'h00, 2'b01, 1'b1, 0, 1'b0);
      run(8'd6,  4'h4, 4'h0, 8'h04, 8'h00, 2'b01, 1'b1, 0, 1'b0);
      check("t5_count_full", 32'(fifo_count), 32'd4);
      run(8'd99, 4'hB, 4'hA, 8'hFB, 8'hFA, 2'b10, 1'b1, 0, 1'b1);
      check("t5_count_stays", 32'(fifo_count),      32'd4);
      check("t5_no_overflow", 32'(overflow_sticky), 32'd0);
      drain();

      // T6: asynchronous reset mid-operation
      out_ready = 1'b0;
      run(8'd7, 4'h1, 4'h1, 8'h01, 8'h01, 2'b01, 1'b1, 0, 1'b0);
      run(8'd8, 4'h2, 4'h2, 8'h02, 8'h02, 2'b01, 1'b1, 0, 1'b0);
      check("t6_count_two", 32'(fifo_count), 32'd2);
      @(posedge clk); #1 start_signal = 1'b1;
      @(posedge clk); #1 process_completed = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid",    32'(out_valid),       32'd0);
      check("t6_rst_count",    32'(fifo_count),      32'd0);
      check("t6_rst_overflow", 32'(overflow_sticky), 32'd0);
      start_signal      = 1'b0;
      process_completed = 1'b0;
      sb.delete();
      exp_idx = 8'd0;
      @(posedge clk); #1 rst_n = 1'b1;
      out_ready = 1'b1;
      run(8'd12, 4'hF, 4'h7, 8'hFF, 8'h07, 2'b01, 1'b1, 0, 1'b0);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
